// File: rtl/memory_pattern_writer_if.sv
// memory_pattern_writer_if
//   Single-port memory bus between the pattern writer (master) and a RAM
//   slave whose read data appears one cycle after the address.
//   addr     : word address, master -> slave
//   data_out : write data, master -> slave
//   write_en : write strobe, master -> slave
//   data_in  : read data, slave -> master
interface memory_pattern_writer_if #(
   parameter int addr_size = 16,
   parameter int word_size = 16
);
   logic [addr_size-1:0] addr;
   logic [word_size-1:0] data_out;
   logic [word_size-1:0] data_in;
   logic                 write_en;

   modport master (output addr, output data_out, output write_en, input data_in);
   modport slave  (input addr, input data_out, input write_en, output data_in);
endinterface

// File: rtl/memory_pattern_writer.sv
// memory_pattern_writer
//   On start, writes array_size pattern words to base_addr.., reads them back
//   and compares each against the pattern. Reports done, a sticky error flag,
//   a saturating mismatch count and the first failing address.
//   clk, reset     : single clock, async active-high reset
//   start          : begin a run (honoured only in IDLE or DONE)
//   bus            : master side of the memory bus
//   busy / done    : run in progress / run finished
//   error, err_count, first_err_addr : results of the last run
module memory_pattern_writer #(
   parameter int                              addr_size     = 16,
   parameter int                              word_size     = 16,
   parameter int                              array_size    = 2,
   parameter logic [addr_size-1:0]            base_addr     = '0,
   parameter logic [array_size*word_size-1:0] array_content = '1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   memory_pattern_writer_if.master  bus,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [15:0]              err_count,
   output logic [addr_size-1:0]     first_err_addr
);
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam int             IW   = $clog2(array_size) + 1;
   localparam logic [IW-1:0]  LAST = IW'(array_size);

   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [addr_size-1:0] addr_q, addr_d;
   logic [word_size-1:0] data_q, data_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [addr_size-1:0] first_q, first_d;
   // compare stage: what the address on the bus this cycle should read back as
   logic                 cmp_vld_q, cmp_vld_d;
   logic [word_size-1:0] cmp_exp_q, cmp_exp_d;
   logic [addr_size-1:0] cmp_addr_q, cmp_addr_d;

   function automatic logic [word_size-1:0] word_at(input logic [IW-1:0] i);
      return array_content[int'(i)*word_size +: word_size];
   endfunction

   // idx holds the index of the word to put on the bus at the coming edge;
   // the bus outputs are registered, so each state computes them one ahead.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      data_d     = data_q;
      we_d       = we_q;
      error_d    = error_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      cmp_vld_d  = 1'b0;
      cmp_exp_d  = cmp_exp_q;
      cmp_addr_d = cmp_addr_q;

      if (cmp_vld_q && (bus.data_in != cmp_exp_q)) begin
         error_d = 1'b1;
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         if (!error_q) first_d = cmp_addr_q;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            addr_d = '0;
            data_d = '0;
            we_d   = 1'b0;
            if (start) begin
               error_d = 1'b0;
               cnt_d   = '0;
               first_d = '0;
               state_d = S_WRITE;
               addr_d  = base_addr;
               data_d  = word_at('0);
               we_d    = 1'b1;
               idx_d   = IW'(1);
            end
         end
         S_WRITE: begin
            if (idx_q == LAST) begin
               state_d    = S_READ;
               we_d       = 1'b0;
               data_d     = '0;
               addr_d     = base_addr;
               cmp_vld_d  = 1'b1;
               cmp_exp_d  = word_at('0);
               cmp_addr_d = base_addr;
               idx_d      = IW'(1);
            end else begin
               addr_d = base_addr + addr_size'(idx_q);
               data_d = word_at(idx_q);
               idx_d  = idx_q + 1'b1;
            end
         end
         S_READ: begin
            if (idx_q == LAST) begin
               // last read data is being compared at this same edge
               state_d = S_DRAIN;
               addr_d  = '0;
               idx_d   = '0;
            end else begin
               addr_d     = base_addr + addr_size'(idx_q);
               cmp_vld_d  = 1'b1;
               cmp_exp_d  = word_at(idx_q);
               cmp_addr_d = base_addr + addr_size'(idx_q);
               idx_d      = idx_q + 1'b1;
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cnt_q      <= '0;
         first_q    <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_exp_q  <= cmp_exp_d;
         cmp_addr_q <= cmp_addr_d;
      end
   end

   assign bus.addr       = addr_q;
   assign bus.data_out   = data_q;
   assign bus.write_en   = we_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_count      = cnt_q;
   assign first_err_addr = first_q;
endmodule

// File: tb/tb_memory_pattern_writer.sv
// tb_memory_pattern_writer
//   Four writer instances with different windows share one clock and reset.
//   Each sees a behavioural RAM whose read data can be overridden per address.
module tb_memory_pattern_writer;
   localparam int ND = 4;
   localparam logic [15:0] BASE [ND] = '{16'h0008, 16'h0020, 16'hFFFF, 16'h0100};
   localparam int          NW   [ND] = '{2, 4, 2, 1};
   localparam logic [63:0] PAT  [ND] = '{64'h1234ABCD, 64'h0123456789ABCDEF,
                                         64'hA5A55A5A, 64'hBEEF};

   typedef struct {int d; logic [15:0] a; logic [15:0] v;} wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [ND-1:0]       start_s = '0;
   logic [ND-1:0][15:0] din_r;
   wire  [ND-1:0]       busy_w, done_w, error_w, we_w;
   wire  [ND-1:0][15:0] cnt_w, first_w, addr_w, dout_w;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] mem [ND][65536];
   logic [15:0] ovr [int];
   wr_t         wlog [$];

   always #5 clk = ~clk;

   memory_pattern_writer_if #(.addr_size(16), .word_size(16)) bus0 ();
   memory_pattern_writer_if #(.addr_size(16), .word_size(16)) bus1 ();
   memory_pattern_writer_if #(.addr_size(16), .word_size(16)) bus2 ();
   memory_pattern_writer_if #(.addr_size(16), .word_size(16)) bus3 ();

   memory_pattern_writer #(.addr_size(16), .word_size(16), .array_size(2),
      .base_addr(16'h0008), .array_content(32'h1234ABCD)) dut0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .bus(bus0.master),
      .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]),
      .err_count(cnt_w[0]), .first_err_addr(first_w[0]));
   memory_pattern_writer #(.addr_size(16), .word_size(16), .array_size(4),
      .base_addr(16'h0020), .array_content(64'h0123456789ABCDEF)) dut1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .bus(bus1.master),
      .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]),
      .err_count(cnt_w[1]), .first_err_addr(first_w[1]));
   memory_pattern_writer #(.addr_size(16), .word_size(16), .array_size(2),
      .base_addr(16'hFFFF), .array_content(32'hA5A55A5A)) dut2 (
      .clk(clk), .reset(reset), .start(start_s[2]), .bus(bus2.master),
      .busy(busy_w[2]), .done(done_w[2]), .error(error_w[2]),
      .err_count(cnt_w[2]), .first_err_addr(first_w[2]));
   memory_pattern_writer #(.addr_size(16), .word_size(16), .array_size(1),
      .base_addr(16'h0100), .array_content(16'hBEEF)) dut3 (
      .clk(clk), .reset(reset), .start(start_s[3]), .bus(bus3.master),
      .busy(busy_w[3]), .done(done_w[3]), .error(error_w[3]),
      .err_count(cnt_w[3]), .first_err_addr(first_w[3]));

   assign addr_w[0] = bus0.addr;  assign dout_w[0] = bus0.data_out;
   assign addr_w[1] = bus1.addr;  assign dout_w[1] = bus1.data_out;
   assign addr_w[2] = bus2.addr;  assign dout_w[2] = bus2.data_out;
   assign addr_w[3] = bus3.addr;  assign dout_w[3] = bus3.data_out;
   assign we_w[0] = bus0.write_en;  assign we_w[1] = bus1.write_en;
   assign we_w[2] = bus2.write_en;  assign we_w[3] = bus3.write_en;
   assign bus0.data_in = din_r[0];  assign bus1.data_in = din_r[1];
   assign bus2.data_in = din_r[2];  assign bus3.data_in = din_r[3];

   function automatic int key(input int d, input logic [15:0] a);
      return d * 65536 + int'(a);
   endfunction

   function automatic logic [15:0] word(input int d, input int i);
      logic [63:0] p;
      p = PAT[d];
      return p[16*i +: 16];
   endfunction

   // Address held mid-cycle is what the slave sees at the next edge, so the
   // write lands and the read data is presented from the falling edge.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (we_w[d]) begin
            mem[d][addr_w[d]] = dout_w[d];
            wlog.push_back('{d, addr_w[d], dout_w[d]});
         end
         if (ovr.exists(key(d, addr_w[d]))) din_r[d] = ovr[key(d, addr_w[d])];
         else din_r[d] = mem[d][addr_w[d]];
      end
   end

   // Expected results: every address reads back what was written unless an
   // override replaces it; mismatches are counted in address order.
   function automatic void model(input int d, output logic e, output logic [15:0] c,
                                 output logic [15:0] f);
      logic [15:0] a, rd;
      e = 1'b0; c = '0; f = '0;
      for (int i = 0; i < NW[d]; i++) begin
         a  = BASE[d] + 16'(i);
         rd = ovr.exists(key(d, a)) ? ovr[key(d, a)] : word(d, i);
         if (rd != word(d, i)) begin
            if (!e) f = a;
            e = 1'b1;
            c = c + 16'd1;
         end
      end
   endfunction

   // Pulses start, then counts edges until done. done_at = -1 if it never came.
   task automatic do_run(input int d, input bit spam, output int done_at, output int busy_n);
      wlog.delete();
      @(negedge clk);
      start_s[d] = 1'b1;
      @(posedge clk);
      done_at = -1;
      busy_n  = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (busy_w[d]) busy_n++;
         if (done_w[d]) begin
            done_at = c;
            break;
         end
         start_s[d] = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start_s[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [67:0] v;
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         v = {busy_w[d], done_w[d], error_w[d], cnt_w[d], first_w[d], addr_w[d],
              we_w[d], dout_w[d]};
         n_checks++;
         if (v !== '0) begin
            n_err++;
            $display("FAIL reset_outputs dut%0d: got %h expected 0", d, v);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clean(input int d);
      int done_at, busy_n;
      logic e;
      logic [15:0] c, f;
      ovr.delete();
      do_run(d, 1'b0, done_at, busy_n);
      model(d, e, c, f);
      n_checks++;
      if (done_at !== 2*NW[d]+2) begin
         n_err++;
         $display("FAIL clean_done_cycle dut%0d: got %0d expected %0d", d, done_at, 2*NW[d]+2);
      end
      n_checks++;
      if (busy_n !== 2*NW[d]+1) begin
         n_err++;
         $display("FAIL clean_busy_len dut%0d: got %0d expected %0d", d, busy_n, 2*NW[d]+1);
      end
      n_checks++;
      if (wlog.size() !== NW[d]) begin
         n_err++;
         $display("FAIL clean_write_count dut%0d: got %0d expected %0d", d, wlog.size(), NW[d]);
      end
      for (int i = 0; i < NW[d] && i < wlog.size(); i++) begin
         n_checks++;
         if (wlog[i].a !== BASE[d] + 16'(i) || wlog[i].v !== word(d, i)) begin
            n_err++;
            $display("FAIL clean_write%0d dut%0d: got (%h,%h) expected (%h,%h)", i, d,
                     wlog[i].a, wlog[i].v, BASE[d] + 16'(i), word(d, i));
         end
      end
      n_checks++;
      if ({error_w[d], cnt_w[d], first_w[d]} !== {e, c, f}) begin
         n_err++;
         $display("FAIL clean_result dut%0d: got %b/%h/%h expected %b/%h/%h", d,
                  error_w[d], cnt_w[d], first_w[d], e, c, f);
      end
   endtask

   task automatic test_bad_word();
      int done_at, busy_n;
      ovr.delete();
      ovr[key(0, 16'h0009)] = 16'hFFFF;
      do_run(0, 1'b0, done_at, busy_n);
      n_checks++;
      if ({done_at == 6, error_w[0], cnt_w[0], first_w[0]} !== {1'b1, 1'b1, 16'd1, 16'h0009}) begin
         n_err++;
         $display("FAIL bad_word: got done@%0d %b/%h/%h expected done@6 1/0001/0009",
                  done_at, error_w[0], cnt_w[0], first_w[0]);
      end
   endtask

   task automatic test_all_zero();
      int done_at, busy_n;
      ovr.delete();
      for (int i = 0; i < NW[1]; i++) ovr[key(1, BASE[1] + 16'(i))] = 16'h0000;
      do_run(1, 1'b0, done_at, busy_n);
      n_checks++;
      if ({error_w[1], cnt_w[1], first_w[1]} !== {1'b1, 16'd4, BASE[1]}) begin
         n_err++;
         $display("FAIL all_zero: got %b/%h/%h expected 1/0004/%h",
                  error_w[1], cnt_w[1], first_w[1], BASE[1]);
      end
   endtask

   task automatic test_start_spam();
      int done_at, busy_n;
      ovr.delete();
      do_run(0, 1'b1, done_at, busy_n);
      n_checks++;
      if (done_at !== 6 || busy_n !== 5) begin
         n_err++;
         $display("FAIL start_spam: got done@%0d busy=%0d expected done@6 busy=5", done_at, busy_n);
      end
   endtask

   task automatic test_random();
      int done_at, busy_n;
      logic e;
      logic [15:0] c, f, a;
      for (int it = 0; it < 8; it++) begin
         ovr.delete();
         for (int i = 0; i < NW[1]; i++) begin
            a = BASE[1] + 16'(i);
            if ($urandom_range(0, 1) == 1) ovr[key(1, a)] = 16'($urandom_range(0, 65535));
         end
         do_run(1, 1'($urandom_range(0, 1)), done_at, busy_n);
         model(1, e, c, f);
         n_checks++;
         if (done_at !== 10 || {error_w[1], cnt_w[1], first_w[1]} !== {e, c, f}) begin
            n_err++;
            $display("FAIL random%0d: got done@%0d %b/%h/%h expected done@10 %b/%h/%h", it,
                     done_at, error_w[1], cnt_w[1], first_w[1], e, c, f);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [67:0] v;
      int done_at, busy_n;
      ovr.delete();
      ovr[key(1, BASE[1])] = ~word(1, 0);
      @(negedge clk);
      start_s[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[1] = 1'b0;
      repeat (NW[1] + 1) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy_w[1], error_w[1]} !== 2'b11) begin
         n_err++;
         $display("FAIL midrun_pre_reset: got busy=%b error=%b expected 1 1", busy_w[1], error_w[1]);
      end
      #1 reset = 1'b1;
      #1;
      v = {busy_w[1], done_w[1], error_w[1], cnt_w[1], first_w[1], addr_w[1], we_w[1], dout_w[1]};
      n_checks++;
      if (v !== '0) begin
         n_err++;
         $display("FAIL midrun_reset_async: got %h expected 0", v);
      end
      @(negedge clk);
      reset = 1'b0;
      ovr.delete();
      do_run(1, 1'b0, done_at, busy_n);
      n_checks++;
      if (done_at !== 10 || busy_n !== 9 || {error_w[1], cnt_w[1]} !== 17'd0) begin
         n_err++;
         $display("FAIL midrun_rerun: got done@%0d busy=%0d err=%b cnt=%h expected done@10 busy=9 0 0",
                  done_at, busy_n, error_w[1], cnt_w[1]);
      end
   endtask

   task automatic test_restart_from_done();
      int done_at, busy_n;
      ovr.delete();
      ovr[key(0, 16'h0008)] = 16'h0000;
      do_run(0, 1'b0, done_at, busy_n);
      n_checks++;
      if ({done_w[0], error_w[0]} !== 2'b11) begin
         n_err++;
         $display("FAIL restart_setup: got done=%b error=%b expected 1 1", done_w[0], error_w[0]);
      end
      ovr.delete();
      @(negedge clk);
      start_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      n_checks++;
      if ({done_w[0], busy_w[0], error_w[0], cnt_w[0], first_w[0]} !== {2'b01, 33'd0}) begin
         n_err++;
         $display("FAIL restart_clear: got done=%b busy=%b %b/%h/%h expected 0 1 0/0000/0000",
                  done_w[0], busy_w[0], error_w[0], cnt_w[0], first_w[0]);
      end
      done_at = -1;
      for (int c = 2; c <= 60; c++) begin
         @(negedge clk);
         if (done_w[0]) begin
            done_at = c;
            break;
         end
      end
      n_checks++;
      if (done_at !== 6 || error_w[0] !== 1'b0) begin
         n_err++;
         $display("FAIL restart_run: got done@%0d error=%b expected done@6 0", done_at, error_w[0]);
      end
   endtask

   initial begin
      test_reset();
      test_clean(0);
      test_bad_word();
      test_all_zero();
      test_start_spam();
      test_clean(2);
      test_clean(3);
      test_clean(1);
      test_random();
      test_reset_mid_run();
      test_restart_from_done();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of the test sequence");
      $fatal(1);
   end
endmodule
